// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory with memory-mapped peripherals.
//   RAM      : byte addresses 0 .. 4*MEM_WORDS-1, little-endian, byte/half/word access.
//   MMIO     : 0x40000000 TH, 0x04 TL, 0x08 TCON {status,irq_en,enable},
//              0x0C LEDS, 0x10 DIGIT (hex nibbles), 0x14 CYCLES (read-only).
// Ports:
//   clk, reset (async, active-high)
//   addr, wdata, mem_read, mem_write, size, unsigned_ld : CPU load/store bus
//   rdata, misaligned : combinational load data / fault flag
//   leds, an, seg     : LED register and multiplexed active-low 7-segment drive
//   irq               : registered timer interrupt level
module dmem_mmio #(
  parameter int MEM_WORDS = 512,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int LED_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic [LED_W-1:0]  leds,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              irq
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [31:0] mem [0:MEM_WORDS-1];

  logic [31:0]         th_r, tl_r, cycles_r;
  logic [2:0]          tcon_r;
  logic [LED_W-1:0]    leds_r;
  logic [4*DIGITS-1:0] digit_r;
  logic [PW-1:0]       presc_r;
  logic [IW-1:0]       idx_r;

  // Decode
  logic          ram_sel, mmio_sel, wr_ok, reg_wr;
  logic [AW-1:0] widx;
  logic [31:0]   ram_word, ram_sh, ram_load, mmio_load;
  logic [3:0]    be;
  logic [31:0]   wd_rep;

  assign misaligned = (mem_read | mem_write) &
                      (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
  assign ram_sel  = (addr < 32'(4 * MEM_WORDS));
  assign mmio_sel = (addr[31:5] == 27'h2000000) && (addr[4:2] <= 3'd5);
  assign widx     = addr[AW+1:2];
  assign wr_ok    = mem_write & ~misaligned;
  assign reg_wr   = wr_ok & mmio_sel & size[1];

  // RAM store: byte enables plus lane-replicated data so any lane picks its byte.
  always_comb begin
    be     = 4'b1111;
    wd_rep = wdata;
    case (size)
      2'b00: begin be = 4'b0001 << addr[1:0]; wd_rep = {4{wdata[7:0]}};  end
      2'b01: begin be = addr[1] ? 4'b1100 : 4'b0011; wd_rep = {2{wdata[15:0]}}; end
      default: ;
    endcase
  end

  // No reset on the array so it maps to block RAM; a store seen during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && ram_sel) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wd_rep[8*b +: 8];
    end
  end

  // Loads
  assign ram_word = mem[widx];
  assign ram_sh   = ram_word >> {addr[1:0], 3'b000};

  always_comb begin
    ram_load = ram_word;
    case (size)
      2'b00: ram_load = unsigned_ld ? {24'h0, ram_sh[7:0]}  : {{24{ram_sh[7]}},  ram_sh[7:0]};
      2'b01: ram_load = unsigned_ld ? {16'h0, ram_sh[15:0]} : {{16{ram_sh[15]}}, ram_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    mmio_load = 32'h0;
    case (addr[4:2])
      3'd0: mmio_load = th_r;
      3'd1: mmio_load = tl_r;
      3'd2: mmio_load = {29'h0, tcon_r};
      3'd3: mmio_load = 32'(leds_r);
      3'd4: mmio_load = 32'(digit_r);
      3'd5: mmio_load = cycles_r;
      default: ;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    if (mem_read && !misaligned) begin
      if (ram_sel)                rdata = ram_load;
      else if (mmio_sel && size[1]) rdata = mmio_load;
    end
  end

  // Timer, registers, scan
  logic       ovf;
  logic [2:0] tcon_nxt;

  assign ovf = tcon_r[0] && (tl_r == 32'hFFFF_FFFF);

  // Software write lands first, overflow status is OR-ed on top.
  always_comb begin
    tcon_nxt = (reg_wr && addr[4:2] == 3'd2) ? wdata[2:0] : tcon_r;
    if (ovf && tcon_r[1]) tcon_nxt[2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_r     <= '0;
      tl_r     <= '0;
      tcon_r   <= '0;
      leds_r   <= '0;
      digit_r  <= '0;
      cycles_r <= '0;
      presc_r  <= '0;
      idx_r    <= '0;
      irq      <= 1'b0;
    end else begin
      cycles_r <= cycles_r + 32'd1;
      irq      <= tcon_r[1] & tcon_r[2];
      tcon_r   <= tcon_nxt;

      if (reg_wr && addr[4:2] == 3'd0) th_r    <= wdata;
      if (reg_wr && addr[4:2] == 3'd3) leds_r  <= wdata[LED_W-1:0];
      if (reg_wr && addr[4:2] == 3'd4) digit_r <= wdata[4*DIGITS-1:0];

      if (reg_wr && addr[4:2] == 3'd1) tl_r <= wdata;
      else if (ovf)                    tl_r <= th_r;
      else if (tcon_r[0])              tl_r <= tl_r + 32'd1;

      if (presc_r == PW'(SCAN_DIV - 1)) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + 1'b1;
      end else begin
        presc_r <= presc_r + 1'b1;
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0; 4'h1: glyph = 8'hF9; 4'h2: glyph = 8'hA4; 4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99; 4'h5: glyph = 8'h92; 4'h6: glyph = 8'h82; 4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80; 4'h9: glyph = 8'h90; 4'hA: glyph = 8'h88; 4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6; 4'hD: glyph = 8'hA1; 4'hE: glyph = 8'h86; default: glyph = 8'h8E;
    endcase
  endfunction

  assign leds = leds_r;
  assign an   = ~(DIGITS'(1) << idx_r);
  assign seg  = glyph(digit_r[4*idx_r +: 4]);

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_read, mem_write, unsigned_ld, misaligned, irq;
  logic [1:0]  size;
  logic [7:0]  leds, seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_mmio #(.MEM_WORDS(512), .DIGITS(4), .SCAN_DIV(4), .LED_W(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .rdata(rdata), .misaligned(misaligned), .leds(leds), .an(an), .seg(seg), .irq(irq)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rd;
    logic        exp_mis;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                       input logic [1:0] s, input logic u);
    addr = a; wdata = d; mem_read = r; mem_write = w; size = s; unsigned_ld = u;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
  endtask

  // Scoreboard: expectation queued at drive time, popped when outputs are sampled.
  task automatic sample_sb();
    sb_t e;
    #1;
    e = sbq.pop_front();
    check({e.name, ".rdata"}, rdata, e.exp_rd);
    check({e.name, ".mis"}, {31'h0, misaligned}, {31'h0, e.exp_mis});
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    sbq.push_back('{name, exp, 1'b0});
    sample_sb();
    idle();
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b0, 1'b1, 2'b10, 1'b0);
    tick();
    idle();
  endtask

  logic [3:0] exp_an  [4];
  logic [7:0] exp_seg [4];
  logic [3:0] prev_an;
  bit         synced;

  initial begin
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    tbl.push_back('{32'h10, 32'h12345678, 0, 1, 2'b10, 0, 32'h0,        0, "sw_10"});
    tbl.push_back('{32'h13, 32'h0,        1, 0, 2'b00, 0, 32'h00000012, 0, "lb_13"});
    tbl.push_back('{32'h10, 32'h0,        1, 0, 2'b00, 0, 32'h00000078, 0, "lb_10"});
    tbl.push_back('{32'h11, 32'h80,       0, 1, 2'b00, 0, 32'h0,        0, "sb_11"});
    tbl.push_back('{32'h10, 32'h0,        1, 0, 2'b10, 0, 32'h12348078, 0, "lw_10"});
    tbl.push_back('{32'h11, 32'h0,        1, 0, 2'b00, 0, 32'hFFFFFF80, 0, "lb_11"});
    tbl.push_back('{32'h11, 32'h0,        1, 0, 2'b00, 1, 32'h00000080, 0, "lbu_11"});
    tbl.push_back('{32'h10, 32'h0,        1, 0, 2'b01, 0, 32'hFFFF8078, 0, "lh_10"});
    tbl.push_back('{32'h12, 32'h0,        1, 0, 2'b01, 1, 32'h00001234, 0, "lhu_12"});
    tbl.push_back('{32'h11, 32'h0,        1, 0, 2'b01, 0, 32'h0,        1, "lh_11"});
    tbl.push_back('{32'h20, 32'hAABBCCDD, 0, 1, 2'b10, 0, 32'h0,        0, "sw_20"});
    tbl.push_back('{32'h22, 32'h11111111, 0, 1, 2'b10, 0, 32'h0,        1, "sw_22"});
    tbl.push_back('{32'h20, 32'h0,        1, 0, 2'b11, 0, 32'hAABBCCDD, 0, "lw_20"});
    tbl.push_back('{32'h22, 32'h0,        0, 0, 2'b10, 0, 32'h0,        0, "idle_22"});
    tbl.push_back('{32'h22, 32'hBEEF,     0, 1, 2'b01, 0, 32'h0,        0, "sh_22"});
    tbl.push_back('{32'h20, 32'h0,        1, 0, 2'b10, 0, 32'hBEEFCCDD, 0, "lw_20b"});
    tbl.push_back('{32'h800, 32'h0,       1, 0, 2'b10, 0, 32'h0,        0, "lw_unmapped"});
    tbl.push_back('{32'h4000000C, 32'h1A5, 0, 1, 2'b10, 0, 32'h0,       0, "sw_leds"});
    tbl.push_back('{32'h4000000C, 32'h0,  1, 0, 2'b10, 0, 32'h000000A5, 0, "lw_leds"});
    tbl.push_back('{32'h4000000C, 32'hFF, 0, 1, 2'b00, 0, 32'h0,        0, "sb_leds"});
    tbl.push_back('{32'h4000000C, 32'h0,  1, 0, 2'b10, 0, 32'h000000A5, 0, "lw_leds2"});
    tbl.push_back('{32'h4000000C, 32'h0,  1, 0, 2'b00, 1, 32'h0,        0, "lb_leds"});
    tbl.push_back('{32'h4000001C, 32'h0,  1, 0, 2'b10, 0, 32'h0,        0, "lw_mmio_gap"});

    // Reset state, sampled with reset held
    idle();
    reset = 1'b1;
    repeat (2) tick();
    check("rst.leds", {24'h0, leds}, 32'h0);
    check("rst.an", {28'h0, an}, 32'hE);
    check("rst.seg", {24'h0, seg}, 32'hC0);
    check("rst.irq", {31'h0, irq}, 32'h0);
    peek("rst.th", 32'h40000000, 32'h0);
    peek("rst.tl", 32'h40000004, 32'h0);
    peek("rst.tcon", 32'h40000008, 32'h0);
    peek("rst.digit", 32'h40000010, 32'h0);
    peek("rst.cycles", 32'h40000014, 32'h0);
    reset = 1'b0;
    tick();

    // Table-driven bus accesses
    foreach (tbl[i]) begin
      drive(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns);
      sbq.push_back('{tbl[i].name, tbl[i].exp_rd, tbl[i].exp_mis});
      sample_sb();
      tick();
      idle();
    end
    check("leds_out", {24'h0, leds}, 32'hA5);

    // Timer overflow / reload / interrupt
    wr32(32'h40000000, 32'hFFFFFFF0);
    wr32(32'h40000004, 32'hFFFFFFFE);
    wr32(32'h40000008, 32'h3);
    peek("tmr.tl0", 32'h40000004, 32'hFFFFFFFE);
    tick();
    peek("tmr.tl1", 32'h40000004, 32'hFFFFFFFF);
    tick();
    peek("tmr.tl_wrap", 32'h40000004, 32'hFFFFFFF0);
    peek("tmr.tcon_st", 32'h40000008, 32'h7);
    check("tmr.irq_pre", {31'h0, irq}, 32'h0);
    tick();
    check("tmr.irq_set", {31'h0, irq}, 32'h1);
    wr32(32'h40000008, 32'h3);
    tick();
    check("tmr.irq_clr", {31'h0, irq}, 32'h0);
    peek("tmr.tcon_clr", 32'h40000008, 32'h3);
    wr32(32'h40000004, 32'h100);
    peek("tmr.tl_wr_prio", 32'h40000004, 32'h100);

    // Reset asserted mid-timer with a store in flight
    drive(32'h20, 32'h55555555, 1'b0, 1'b1, 2'b10, 1'b0);
    reset = 1'b1;
    tick();
    idle();
    reset = 1'b0;
    peek("rst2.ram", 32'h20, 32'hBEEFCCDD);
    peek("rst2.tl", 32'h40000004, 32'h0);
    peek("rst2.tcon", 32'h40000008, 32'h0);
    check("rst2.irq", {31'h0, irq}, 32'h0);
    check("rst2.leds", {24'h0, leds}, 32'h0);
    repeat (3) tick();
    peek("rst2.cycles", 32'h40000014, 32'h3);
    peek("rst2.tl_hold", 32'h40000004, 32'h0);

    // Digit scan
    wr32(32'h40000010, 32'h00003210);
    synced  = 1'b0;
    prev_an = an;
    for (int c = 0; c < 40 && !synced; c++) begin
      tick();
      if (an == 4'b1110 && prev_an != 4'b1110) synced = 1'b1;
      prev_an = an;
    end
    if (!synced) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scan.sync: an never advanced into digit 0, last an %b", an);
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          check($sformatf("scan.an[%0d.%0d]", k, j), {28'h0, an}, {28'h0, exp_an[k]});
          check($sformatf("scan.seg[%0d.%0d]", k, j), {24'h0, seg}, {24'h0, exp_seg[k]});
          tick();
        end
      end
      check("scan.wrap", {28'h0, an}, 32'hE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, RAM depth in 32-bit words.
REQ-002 SHALL have parameter DIGITS, default 4, number of 7-segment digits scanned (1-8).
REQ-003 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot.
REQ-004 SHALL have parameter LED_W, default 8, LED register width (1-32).
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port addr  in  32  byte address.
REQ-008 SHALL have port wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port mem_read  in  1  load strobe.
REQ-010 SHALL have port mem_write  in  1  store strobe.
REQ-011 SHALL have port size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 SHALL have port unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-013 SHALL have port rdata  out  32  load data, combinational.
REQ-014 SHALL have port misaligned  out  1  access fault flag, combinational.
REQ-015 SHALL have port leds  out  LED_W  LED register.
REQ-016 SHALL have port an  out  DIGITS  digit enables, active-low, one-hot.
REQ-017 SHALL have port seg  out  8  segments {dp,g..a}, active-low.
REQ-018 SHALL have port irq  out  1  timer interrupt, level, registered.

Function
REQ-019 SHALL map RAM at byte addresses 0 .. 4*MEM_WORDS-1, little-endian byte lanes.
REQ-020 SHALL map word registers: 0x40000000 TH (timer reload, RW), 0x40000004 TL (timer count, RW), 0x40000008 TCON (bit0 enable, bit1 irq_en, bit2 status; RW, upper bits read 0), 0x4000000C LEDS (RW, LED_W bits), 0x40000010 DIGIT (RW, 4*DIGITS hex nibbles, nibble k drives digit k), 0x40000014 CYCLES (RO free-running 32-bit counter).
REQ-021 SHALL assert misaligned when (mem_read|mem_write) and (size=01 with addr[0]=1, or size>=10 with addr[1:0]!=0).
REQ-022 SHALL suppress the write and return rdata=0 on a misaligned access.
REQ-023 SHALL return rdata=0 when mem_read=0 or addr is unmapped; writes to unmapped or read-only addresses SHALL be ignored.
REQ-024 SHALL perform stores synchronously at the clk edge; byte/half stores update only the addressed lanes of RAM.
REQ-025 SHALL restrict MMIO registers to word access; sub-word MMIO stores SHALL be ignored and sub-word MMIO loads SHALL return 0.
REQ-026 SHALL extract sub-word loads from addr-selected lanes and extend per unsigned_ld.
REQ-027 SHALL increment TL by 1 each cycle while TCON.enable=1; on TL=0xFFFFFFFF, TL SHALL load TH and TCON.status SHALL set if irq_en=1.
REQ-028 SHALL give a software write to TL priority over increment/reload in the same cycle.
REQ-029 SHALL apply a software write to TCON first, then OR in a same-cycle overflow status set.
REQ-030 SHALL drive irq = registered (TCON.irq_en & TCON.status); software clears by writing status=0.
REQ-031 SHALL run a prescaler 0..SCAN_DIV-1; on terminal count the digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-032 SHALL drive an low only at the current index, and seg as the active-low hex glyph (0-F) of that nibble, dp=1.
REQ-033 SHALL increment CYCLES every cycle, wrapping at 2^32.

Reset
REQ-034 SHALL on reset clear TH, TL, TCON, LEDS, DIGIT, CYCLES, prescaler and digit index; irq=0, leds=0, an=~1 (digit 0), seg=glyph 0 (0xC0).
REQ-035 SHALL NOT clear RAM on reset (block-RAM inference); RAM initial content SHALL be zero at configuration.
REQ-036 SHALL on reset mid-store discard the store; the cycle after deassertion SHALL behave as idle.

Verification
REQ-037 SHALL cover: sw 0x12345678 @0x10, lb @0x13 signed -> 0x00000012; lb @0x10 -> 0x00000078; sb 0x80 @0x11 then lw @0x10 -> 0x12348078; lb @0x11 signed -> 0xFFFFFF80.
REQ-038 SHALL cover: lh @0x11 -> misaligned=1, rdata=0; sw @0x22 -> misaligned=1, RAM unchanged.
REQ-039 SHALL cover: TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> TL wraps to 0xFFFFFFF0 after 2 cycles, irq=1 one cycle later; write TCON=3 -> irq=0.
REQ-040 SHALL cover: SCAN_DIV=4, DIGIT=0x00003210 -> an cycles 1110,1101,1011,0111 every 4 clks, seg 0xC0,0xF9,0xA4,0xB0.
REQ-041 SHALL cover: write LEDS=0x1A5, LED_W=8 -> leds=0xA5; assert reset mid-timer -> TL=0, irq=0, RAM contents retained.
